// File: rtl/serial_mag_compare.sv
// serial_mag_compare: bit-serial unsigned magnitude comparator.
// Operands are captured in IDLE, scanned MSB-first in SHIFT (one bit per
// clock), and the eq/gt/lt result is held in DONE until the consumer takes it.
// The first differing bit decides the result; lower-order bits are ignored.
// Optional feature macro: SERIAL_MAG_COMPARE_EARLY_EXIT_EN -- when defined,
// the SHIFT edge that decides gt/lt goes straight to DONE.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// SHIFT | scanning operand bits MSB-first
// DONE  | result valid, waiting for out_ready

module serial_mag_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  // Counter must hold WIDTH-1; keep it at least one bit wide for WIDTH=1.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;

  logic bit_a;
  logic bit_b;
  logic decided;
  logic hit_gt;
  logic hit_lt;

  // Handshake flags are pure state decodes so they follow reset immediately.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Decision for the bit currently at the top of the shift registers.
  always_comb begin
    bit_a   = sh_a[WIDTH-1];
    bit_b   = sh_b[WIDTH-1];
    decided = gt | lt;
    hit_gt  = ~decided & bit_a & ~bit_b;
    hit_lt  = ~decided & ~bit_a & bit_b;
  end

  // Sequencer: capture, serial scan, and result hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      cnt   <= '0;
      eq    <= 1'b0;
      gt    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= a_in;
            sh_b  <= b_in;
            gt    <= 1'b0;
            lt    <= 1'b0;
            eq    <= 1'b0;
            cnt   <= CW'(WIDTH - 1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (hit_gt) gt <= 1'b1;
          if (hit_lt) lt <= 1'b1;
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            // Last bit: equal only if nothing was ever decided.
            eq    <= ~(decided | hit_gt | hit_lt);
            state <= DONE;
          end
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
          // Once decided, the remaining bits cannot change the answer.
          if (hit_gt | hit_lt) state <= DONE;
`endif
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_compare.sv
// Directed bench for serial_mag_compare (WIDTH=8). Expected latencies follow
// the build: SERIAL_MAG_COMPARE_EARLY_EXIT_EN shortens decided cases.

module tb_serial_mag_compare;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a_in = '0;
  logic [WIDTH-1:0] b_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic             eq;
  logic             gt;
  logic             lt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  serial_mag_compare #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .eq        (eq),
    .gt        (gt),
    .lt        (lt)
  );

  always #5 clk = ~clk;

  // Expected edges from accept to out_valid; first_diff < 0 means equal.
  function automatic int exp_lat(int first_diff);
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
    if (first_diff >= 0) return WIDTH - first_diff;
`endif
    return WIDTH;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until out_valid, bounded; returns edges taken.
  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input int first_diff, input logic e, input logic g, input logic l);
    int n;
    out_ready = 1'b1;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    step();
    chk({tag, "_accepted"}, int'(in_ready), 0);
    in_valid = 1'b0;
    wait_done(n);
    chk({tag, "_latency"}, n, exp_lat(first_diff));
    chk({tag, "_res"}, int'({eq, gt, lt}), int'({e, g, l}));
    step();
    chk({tag, "_back_idle"}, int'({in_ready, out_valid}), 2);
  endtask

  initial begin
    int n;
    // Asynchronous reset: outputs must settle without any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", int'({in_ready, out_valid, eq, gt, lt}), 5'b10000);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_reset_idle", int'({in_ready, out_valid}), 2);

    run_op("eq_a5",  8'hA5, 8'hA5, -1, 1'b1, 1'b0, 1'b0);
    run_op("gt_80",  8'h80, 8'h7F,  7, 1'b0, 1'b1, 1'b0);
    run_op("lt_02",  8'h02, 8'h03,  0, 1'b0, 1'b0, 1'b1);
    run_op("lt_00ff", 8'h00, 8'hFF, 7, 1'b0, 1'b0, 1'b1);
    run_op("gt_bit3", 8'h5C, 8'h54, 3, 1'b0, 1'b1, 1'b0);

    // Backpressure with a new pair offered the whole time.
    out_ready = 1'b0;
    a_in = 8'hFF;
    b_in = 8'h00;
    in_valid = 1'b1;
    step();
    a_in = 8'h12;
    b_in = 8'h34;
    wait_done(n);
    chk("bp_latency", n, exp_lat(7));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", int'({out_valid, in_ready, eq, gt, lt}), 5'b10010);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_idle", int'({in_ready, out_valid}), 2);
    step();
    chk("bp_new_accept", int'(in_ready), 0);
    in_valid = 1'b0;
    wait_done(n);
    chk("bp2_latency", n, exp_lat(5));
    chk("bp2_res", int'({eq, gt, lt}), 3'b001);
    step();

    // Reset in the middle of an operation.
    out_ready = 1'b0;
    a_in = 8'h10;
    b_in = 8'h20;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
`ifdef SERIAL_MAG_COMPARE_EARLY_EXIT_EN
    chk("abort_pre_valid", int'(out_valid), 1);
`else
    chk("abort_pre_valid", int'(out_valid), 0);
`endif
    rst = 1'b1;
    #1;
    chk("abort_reset_now", int'({in_ready, out_valid, eq, gt, lt}), 5'b10000);
    step();
    chk("abort_reset_hold", int'({in_ready, out_valid, eq, gt, lt}), 5'b10000);
    rst = 1'b0;
    run_op("eq_00", 8'h00, 8'h00, -1, 1'b1, 1'b0, 1'b0);

    // Operand inputs wiggle during SHIFT; result must come from captured pair.
    out_ready = 1'b1;
    a_in = 8'h40;
    b_in = 8'h3F;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      a_in = 8'($urandom);
      b_in = 8'($urandom);
      step();
      n++;
    end
    chk("noise_latency", n, exp_lat(6));
    chk("noise_res", int'({eq, gt, lt}), 3'b010);
    step();
    chk("noise_idle", int'({in_ready, out_valid}), 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/serial_mag_compare.md
SERIAL_MAG_COMPARE -- requirements
Module: serial_mag_compare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 1 to 32).
REQ-002 The block SHALL have port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  operand pair a_in/b_in is offered.
REQ-005 The block SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 The block SHALL have port a_in  input  WIDTH  operand A, unsigned.
REQ-007 The block SHALL have port b_in  input  WIDTH  operand B, unsigned.
REQ-008 The block SHALL have port out_valid  output  1  eq/gt/lt hold a valid result.
REQ-009 The block SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 The block SHALL have port eq  output  1  A == B.
REQ-011 The block SHALL have port gt  output  1  A > B.
REQ-012 The block SHALL have port lt  output  1  A < B.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-015 Accept SHALL occur on an edge with state IDLE and in_valid=1, and SHALL load A/B shift registers, clear gt/lt decision flags, set bit counter to WIDTH-1 and move to SHIFT.
REQ-016 Each SHIFT edge SHALL compare the current MSBs of both shift registers and, if no decision is latched and the bits differ, latch gt=1 (A bit 1, B bit 0) or lt=1 (A bit 0, B bit 1), then shift both left by one and decrement the counter.
REQ-017 Once latched, gt/lt SHALL NOT change for the remainder of that operation; lower-order bits SHALL be ignored.
REQ-018 The SHIFT edge processing bit 0 (counter=0) SHALL move to DONE; eq SHALL be registered as 1 if neither gt nor lt is latched.
REQ-019 Without early exit, out_valid SHALL rise after exactly WIDTH edges following the accepting edge.
REQ-020 In DONE, exactly one of eq/gt/lt SHALL be 1 and all three SHALL hold stable until out_valid&out_ready.
REQ-021 An edge in DONE with out_ready=1 SHALL return to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-022 in_valid, a_in and b_in SHALL be ignored outside IDLE; a new pair SHALL be accepted no earlier than the edge after the result handshake.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 WIDTH=1 SHALL work: one SHIFT edge, then DONE.

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, eq=0, gt=0, lt=0, out_valid=0, in_ready=1, counter=0, shift registers=0, independent of clk.
REQ-026 Reset asserted during SHIFT or DONE SHALL abort the operation with no result delivered; the first edge after release SHALL be able to accept.

Configuration
REQ-027 Macro SERIAL_MAG_COMPARE_EARLY_EXIT_EN SHALL control early termination.
REQ-028 With the macro defined, the SHIFT edge that latches gt or lt SHALL move directly to DONE; for first differing bit index i (MSB=WIDTH-1), out_valid SHALL rise WIDTH-i edges after the accepting edge; equal operands SHALL still take WIDTH edges.
REQ-029 Without the macro, latency SHALL always be WIDTH edges per REQ-019.

Verification (WIDTH=8)
REQ-030 A=0xA5, B=0xA5, out_ready=1 -> out_valid 8 edges after accept, eq=1, gt=0, lt=0; in_ready returns 1 one edge later.
REQ-031 A=0x80, B=0x7F -> gt=1; latency 8 edges without macro, 1 edge with SERIAL_MAG_COMPARE_EARLY_EXIT_EN.
REQ-032 A=0x02, B=0x03 -> lt=1; latency 8 edges both configurations (difference at bit 0).
REQ-033 A=0xFF, B=0x00, out_ready=0 for 5 cycles after out_valid, in_valid=1 with new operands held throughout -> gt=1 stable, in_ready=0, new pair accepted only on the edge after out_ready=1 handshake plus one IDLE cycle.
REQ-034 Accept A=0x10, B=0x20, assert rst for 1 cycle after 3 SHIFT edges -> all outputs reset values immediately, no out_valid; subsequent A=0x00, B=0x00 -> eq=1 after 8 edges.
REQ-035 Change a_in/b_in every cycle during SHIFT after accepting A=0x40, B=0x3F -> result gt=1, unaffected by the changes.
